vfu_mask_router: RTL

Parametrised successor to the lane functional-unit stage's mask/saturation glue. It sits between the lane's mask-unit interface and the `NrFUs` lane functional units. Each incoming mask beat is tagged with a vector-instruction ID and routed only to the unit that owns that instruction, through a per-unit buffer. This removes the old broadcast-and-OR scheme, which wrongly accepted a mask in two units when masked instructions ran in more than one unit at once. The block also keeps a sticky saturation flag for the dispatcher.

---
 rtl/vfu_mask_router_if.sv | 25 ++
 rtl/vfu_mask_router.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/vfu_mask_router_if.sv
// Mask-unit to router handshake.
// The mask unit is the master; the router is the slave.
interface vfu_mask_router_if #(
  parameter int unsigned StrbW = 8,
  parameter int unsigned VidW  = 3
);
  logic [StrbW-1:0] mask_i;
  logic [VidW-1:0]  mask_id_i;
  logic             mask_valid_i;
  logic             mask_ready_o;

  modport master (
    output mask_i,
    output mask_id_i,
    output mask_valid_i,
    input  mask_ready_o
  );

  modport slave (
    input  mask_i,
    input  mask_id_i,
    input  mask_valid_i,
    output mask_ready_o
  );
endinterface

// File: rtl/vfu_mask_router.sv
// Routes tagged mask beats to the owning lane unit through per-unit FIFOs.
// Also keeps the sticky vxsat flag for the dispatcher.
module vfu_mask_router #(
  parameter int unsigned NrFUs     = 2,
  parameter int unsigned NrVInsn   = 8,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned FifoDepth = 2,
  localparam int unsigned StrbW = DataWidth / 8,
  localparam int unsigned VidW  =
    (NrVInsn > 1) ? $clog2(NrVInsn) : 1,
  localparam int unsigned FuW   =
    (NrFUs > 1) ? $clog2(NrFUs) : 1
) (
  input  logic clk_i,
  input  logic rst_ni,

  input  logic                   vinsn_issue_valid_i,
  input  logic [VidW-1:0]        vinsn_issue_id_i,
  input  logic [FuW-1:0]         vinsn_issue_fu_i,
  input  logic [NrFUs-1:0][NrVInsn-1:0] vinsn_done_i,

  vfu_mask_router_if.slave       mask_if,

  output logic [NrFUs-1:0][StrbW-1:0] fu_mask_o,
  output logic [NrFUs-1:0]       fu_mask_valid_o,
  input  logic [NrFUs-1:0]       fu_mask_ready_i,

  input  logic [NrFUs-1:0]       fu_vxsat_i,
  input  logic                   vxsat_clr_i,
  output logic                   vxsat_flag_o,
  output logic                   mask_orphan_o
);

  localparam int unsigned PtrW =
    (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int unsigned CntW = $clog2(FifoDepth + 1);

  logic [NrVInsn-1:0]          own_valid_q;
  logic [NrVInsn-1:0][FuW-1:0] own_fu_q;
  logic [NrVInsn-1:0]          done_hit;

  logic [NrFUs-1:0][FifoDepth-1:0][StrbW-1:0] mem_q;
  logic [NrFUs-1:0][PtrW-1:0] wptr_q;
  logic [NrFUs-1:0][PtrW-1:0] rptr_q;
  logic [NrFUs-1:0][CntW-1:0] cnt_q;

  logic [NrFUs-1:0] full;
  logic [NrFUs-1:0] empty;
  logic [NrFUs-1:0] sel;
  logic [NrFUs-1:0] push;
  logic [NrFUs-1:0] pop;
  logic             hit;
  logic [FuW-1:0]   owner;
  logic             orphan_q;
  logic             flag_q;

  function automatic logic [PtrW-1:0] ptr_inc(
    input logic [PtrW-1:0] p
  );
    return (p == PtrW'(FifoDepth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  always_comb begin
    hit   = own_valid_q[mask_if.mask_id_i];
    owner = own_fu_q[mask_if.mask_id_i];
    full  = '0;
    empty = '0;
    sel   = '0;
    pop   = '0;
    for (int f = 0; f < NrFUs; f++) begin
      full[f]  = cnt_q[f] == CntW'(FifoDepth);
      empty[f] = cnt_q[f] == '0;
      sel[f]   = hit && (owner == FuW'(f));
      pop[f]   = !empty[f] && fu_mask_ready_i[f];
    end
    // Ready looks only at the owner's fill level, never at fu ready.
    mask_if.mask_ready_o = ~|(sel & full);
    push = sel & ~full & {NrFUs{mask_if.mask_valid_i}};
  end

  always_comb begin
    done_hit = '0;
    for (int v = 0; v < NrVInsn; v++) begin
      for (int f = 0; f < NrFUs; f++) begin
        if (vinsn_done_i[f][v] &&
            own_fu_q[v] == FuW'(f)) begin
          done_hit[v] = own_valid_q[v];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      own_valid_q <= '0;
      own_fu_q    <= '0;
    end else begin
      for (int v = 0; v < NrVInsn; v++) begin
        if (vinsn_issue_valid_i &&
            vinsn_issue_id_i == VidW'(v)) begin
          own_valid_q[v] <= 1'b1;
          own_fu_q[v]    <= vinsn_issue_fu_i;
        end else if (done_hit[v]) begin
          own_valid_q[v] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      for (int f = 0; f < NrFUs; f++) begin
        if (push[f]) begin
          mem_q[f][wptr_q[f]] <= mask_if.mask_i;
          wptr_q[f] <= ptr_inc(wptr_q[f]);
        end
        if (pop[f]) begin
          rptr_q[f] <= ptr_inc(rptr_q[f]);
        end
        if (push[f] && !pop[f]) begin
          cnt_q[f] <= cnt_q[f] + CntW'(1);
        end else if (pop[f] && !push[f]) begin
          cnt_q[f] <= cnt_q[f] - CntW'(1);
        end
      end
    end
  end

  // Set beats clear so a saturation event is never lost.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      flag_q   <= 1'b0;
      orphan_q <= 1'b0;
    end else begin
      orphan_q <= mask_if.mask_valid_i && !hit;
      if (|fu_vxsat_i) begin
        flag_q <= 1'b1;
      end else if (vxsat_clr_i) begin
        flag_q <= 1'b0;
      end
    end
  end

  always_comb begin
    for (int f = 0; f < NrFUs; f++) begin
      fu_mask_o[f] = mem_q[f][rptr_q[f]];
    end
    fu_mask_valid_o = ~empty;
  end

  assign vxsat_flag_o  = flag_q;
  assign mask_orphan_o = orphan_q;

endmodule
